// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the CPU read-channel arbiter: requester indices,
// FSM state encoding and AXI burst codes.
package axi_read_arbiter_pkg;

    localparam int RD_REQ_DCACHE  = 0;
    localparam int RD_REQ_UNCACHE = 1;
    localparam int RD_REQ_ICACHE  = 2;
    localparam int RD_REQ_NUM     = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Last-owner pointer reset value; makes the first round-robin search start at 0.
    localparam logic [1:0] RD_PTR_RESET = 2'd2;

endpackage

// File: rtl/axi_read_arbiter_grant_sel.sv
// Combinational winner select: searches requesters starting one past i_last
// (wrapping mod 3) and returns a one-hot grant plus the winner index.
module rd_grant_sel
    import axi_read_arbiter_pkg::*;
(
    input  logic [RD_REQ_NUM-1:0] i_req,
    input  logic [1:0]            i_last,
    output logic [RD_REQ_NUM-1:0] o_grant,
    output logic [1:0]            o_idx,
    output logic                  o_any
);

    logic [1:0] w_order [RD_REQ_NUM];

    always_comb begin
        case (i_last)
            2'd0: begin
                w_order[0] = 2'd1;
                w_order[1] = 2'd2;
                w_order[2] = 2'd0;
            end
            2'd1: begin
                w_order[0] = 2'd2;
                w_order[1] = 2'd0;
                w_order[2] = 2'd1;
            end
            default: begin
                w_order[0] = 2'd0;
                w_order[1] = 2'd1;
                w_order[2] = 2'd2;
            end
        endcase
    end

    // Walk from lowest to highest priority so the earliest candidate wins.
    always_comb begin
        o_idx = 2'd0;
        for (int k = RD_REQ_NUM - 1; k >= 0; k--) begin
            if (i_req[w_order[k]]) begin
                o_idx = w_order[k];
            end
        end
        o_any   = |i_req;
        o_grant = o_any ? (RD_REQ_NUM'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read address/data channel pair among DCache, uncache and ICache,
// one transaction at a time. Define AXI_RD_ARB_RR_EN for round-robin grants.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_REQ_NUM-1:0]        s_arvalid,
    input  logic [RD_REQ_NUM*ADDR_W-1:0] s_araddr,
    input  logic [RD_REQ_NUM*LEN_W-1:0]  s_arlen,
    input  logic [RD_REQ_NUM*3-1:0]      s_arsize,
    output logic [RD_REQ_NUM-1:0]        s_arready,
    output logic [RD_REQ_NUM-1:0]        s_rvalid,
    output logic [DATA_W-1:0]            s_rdata,
    output logic [1:0]                   s_rresp,
    output logic                         s_rlast,
    input  logic [RD_REQ_NUM-1:0]        s_rready,
    output logic                         m_arvalid,
    output logic [3:0]                   m_arid,
    output logic [ADDR_W-1:0]            m_araddr,
    output logic [LEN_W-1:0]             m_arlen,
    output logic [2:0]                   m_arsize,
    output logic [1:0]                   m_arburst,
    input  logic                         m_arready,
    input  logic                         m_rvalid,
    input  logic [DATA_W-1:0]            m_rdata,
    input  logic [1:0]                   m_rresp,
    input  logic                         m_rlast,
    output logic                         m_rready,
    output arb_state_t                   o_dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never waits on ready, and the AR payload is held
    // stable from registers for as long as m_arvalid is high.

    arb_state_t                r_state;
    arb_state_t                w_next;
    logic [1:0]                r_owner;
    logic [ADDR_W-1:0]         r_addr;
    logic [LEN_W-1:0]          r_len;
    logic [2:0]                r_size;
    logic [RD_REQ_NUM-1:0]     w_grant;
    logic [1:0]                w_idx;
    logic                      w_any;
    logic                      w_grant_en;
    logic [1:0]                w_last_ptr;

    assign w_grant_en = (r_state == ARB_IDLE) && w_any;

`ifdef AXI_RD_ARB_RR_EN
    logic [1:0] r_last_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_ptr <= RD_PTR_RESET;
        end else if (w_grant_en) begin
            r_last_ptr <= w_idx;
        end
    end

    assign w_last_ptr = r_last_ptr;
`else
    // Pointer pinned to the last index so the search is always 0 > 1 > 2.
    assign w_last_ptr = 2'(RD_REQ_ICACHE);
`endif

    rd_grant_sel u_grant_sel (
        .i_req   (s_arvalid),
        .i_last  (w_last_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
        end else if (w_grant_en) begin
            r_owner <= w_idx;
            r_addr  <= s_araddr[int'(w_idx)*ADDR_W +: ADDR_W];
            r_len   <= s_arlen[int'(w_idx)*LEN_W +: LEN_W];
            r_size  <= s_arsize[int'(w_idx)*3 +: 3];
        end
    end

    always_comb begin
        w_next    = r_state;
        s_arready = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_rvalid  = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    s_arready = w_grant;
                    w_next    = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    w_next = ARB_DATA;
                end
            end
            ARB_DATA: begin
                // Error responses pass through untouched; only RLAST ends ownership.
                m_rready           = s_rready[r_owner];
                s_rvalid[r_owner]  = m_rvalid;
                s_rdata            = m_rdata;
                s_rresp            = m_rresp;
                s_rlast            = m_rlast;
                if (m_rvalid && s_rready[r_owner] && m_rlast) begin
                    w_next = ARB_IDLE;
                end
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    assign m_arid      = {2'b00, r_owner};
    assign m_araddr    = r_addr;
    assign m_arlen     = r_len;
    assign m_arsize    = r_size;
    assign m_arburst   = (r_len != '0) ? BURST_INCR : BURST_FIXED;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: transaction-level model compared
// every cycle, an expected-beat queue, and directed scenarios with literal checks.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int NREQ   = 3;
`ifdef AXI_RD_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        s_arvalid;
    logic [NREQ*ADDR_W-1:0] s_araddr;
    logic [NREQ*LEN_W-1:0]  s_arlen;
    logic [NREQ*3-1:0]      s_arsize;
    logic [NREQ-1:0]        s_arready;
    logic [NREQ-1:0]        s_rvalid;
    logic [DATA_W-1:0]      s_rdata;
    logic [1:0]             s_rresp;
    logic                   s_rlast;
    logic [NREQ-1:0]        s_rready;
    logic                   m_arvalid;
    logic [3:0]             m_arid;
    logic [ADDR_W-1:0]      m_araddr;
    logic [LEN_W-1:0]       m_arlen;
    logic [2:0]             m_arsize;
    logic [1:0]             m_arburst;
    logic                   m_arready;
    logic                   m_rvalid;
    logic [DATA_W-1:0]      m_rdata;
    logic [1:0]             m_rresp;
    logic                   m_rlast;
    logic                   m_rready;
    arb_state_t             o_dbg_state;

    axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rready(s_rready),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rready(m_rready), .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;
    int cyc;

    // Transaction-level model: phase 0 = no transaction, 1 = address pending, 2 = data.
    int                md_phase;
    int                md_owner;
    logic [ADDR_W-1:0] md_addr;
    logic [LEN_W-1:0]  md_len;
    logic [2:0]        md_size;
    int                md_ptr;

    // Slave side and requester behaviour.
    int                sl_left;
    int                sl_idx;
    logic [DATA_W-1:0] sl_base;
    logic              ar_ready_en;
    logic              hold_req;

    // Scoreboard: expected beats as {requester, data}.
    logic [DATA_W+1:0] exp_q[$];
    int                delivered[NREQ];
    logic [DATA_W-1:0] last_data[NREQ];
    int                grant_idx_q[$];
    int                grant_cyc_q[$];
    int                rlast_cyc_q[$];
    int                exp_seq[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] req, input int ptr);
        int start;
        start = RR_MODE ? (ptr + 1) % NREQ : 0;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        md_phase = 0;
        md_owner = 0;
        md_addr  = '0;
        md_len   = '0;
        md_size  = '0;
        md_ptr   = 2;
    endtask

    task automatic compare_outputs();
        int                w;
        logic [NREQ-1:0]   e_arready;
        logic [NREQ-1:0]   e_rvalid;
        arb_state_t        e_state;
        w         = pick(s_arvalid, md_ptr);
        e_arready = (md_phase == 0 && w >= 0) ? NREQ'(1 << w) : '0;
        e_rvalid  = (md_phase == 2 && m_rvalid) ? NREQ'(1 << md_owner) : '0;
        e_state   = (md_phase == 0) ? ARB_IDLE : (md_phase == 1) ? ARB_ADDR : ARB_DATA;
        chk("s_arready", s_arready, e_arready);
        chk("m_arvalid", m_arvalid, md_phase == 1);
        chk("m_arid", m_arid, md_owner);
        chk("m_araddr", m_araddr, md_addr);
        chk("m_arlen", m_arlen, md_len);
        chk("m_arsize", m_arsize, md_size);
        chk("m_arburst", m_arburst, (md_len != 0) ? 2'b01 : 2'b00);
        chk("m_rready", m_rready, (md_phase == 2) ? s_rready[md_owner] : 1'b0);
        chk("s_rvalid", s_rvalid, e_rvalid);
        chk("s_rdata", s_rdata, (md_phase == 2) ? m_rdata : '0);
        chk("s_rresp", s_rresp, (md_phase == 2) ? m_rresp : 2'b00);
        chk("s_rlast", s_rlast, (md_phase == 2) ? m_rlast : 1'b0);
        chk("state", o_dbg_state, e_state);
    endtask

    // One clock: compare at negedge, advance model, then drive inputs after the edge.
    task automatic cycle();
        logic [NREQ-1:0] grant_seen;
        logic [DATA_W+1:0] e;
        bit   ar_hs;
        bit   r_hs;
        int   w;
        int   new_left;
        @(negedge clk);
        compare_outputs();
        grant_seen = s_arready;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_seen[i]) begin
                grant_idx_q.push_back(i);
                grant_cyc_q.push_back(cyc);
            end
            if (s_rvalid[i] && s_rready[i]) begin
                delivered[i]++;
                last_data[i] = s_rdata;
                if (s_rlast) rlast_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_beat: unexpected beat %0h to requester %0d (cycle %0d)", s_rdata, i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_beat", {2'(i), s_rdata}, e);
                end
            end
        end
        ar_hs    = (md_phase == 1) && m_arready;
        r_hs     = (md_phase == 2) && m_rvalid && s_rready[md_owner];
        new_left = int'(md_len) + 1;
        if (ar_hs) begin
            for (int k = 0; k <= int'(md_len); k++) exp_q.push_back({2'(md_owner), sl_base + DATA_W'(k)});
        end
        if (rst) begin
            model_reset();
        end else begin
            case (md_phase)
                0: begin
                    w = pick(s_arvalid, md_ptr);
                    if (w >= 0) begin
                        md_owner = w;
                        md_addr  = s_araddr[w*ADDR_W +: ADDR_W];
                        md_len   = s_arlen[w*LEN_W +: LEN_W];
                        md_size  = s_arsize[w*3 +: 3];
                        md_ptr   = w;
                        md_phase = 1;
                    end
                end
                1: if (m_arready) md_phase = 2;
                default: if (r_hs && m_rlast) md_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!hold_req) s_arvalid = s_arvalid & ~grant_seen;
        if (rst) sl_left = 0;
        if (ar_hs) begin
            sl_left = new_left;
            sl_idx  = 0;
        end
        if (r_hs) begin
            sl_left--;
            sl_idx++;
        end
        m_arready = ar_ready_en;
        m_rvalid  = (sl_left > 0);
        m_rdata   = sl_base + DATA_W'(sl_idx);
        m_rlast   = (sl_left == 1);
        m_rresp   = (sl_idx == 2) ? 2'b10 : 2'b00;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                           input logic [2:0] size);
        s_araddr[i*ADDR_W +: ADDR_W] = addr;
        s_arlen[i*LEN_W +: LEN_W]    = len;
        s_arsize[i*3 +: 3]           = size;
        s_arvalid[i]                 = 1'b1;
    endtask

    task automatic clear_logs();
        grant_idx_q.delete();
        grant_cyc_q.delete();
        rlast_cyc_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            delivered[i] = 0;
            last_data[i] = '0;
        end
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (md_phase == 0 && s_arvalid == '0 && sl_left == 0) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, phase %0d", name, budget, md_phase);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_rready = '1;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        ar_ready_en = 1'b1; hold_req = 1'b0;
        sl_left = 0; sl_idx = 0; sl_base = '0;
        model_reset();
        clear_logs();
        exp_seq = RR_MODE ? '{0, 1, 2, 0, 1} : '{0, 0, 0, 0, 0};

        // Reset state
        cycle();
        cycle();
        chk("rst_arready", s_arready, 3'b000);
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_arburst", m_arburst, 2'b00);
        chk("rst_rvalid", s_rvalid, 3'b000);
        chk("rst_state", o_dbg_state, ARB_IDLE);
        rst = 1'b0;

        // DCache 8-beat burst
        clear_logs();
        sl_base = 32'hA0;
        set_req(0, 32'h1FC0_0040, 8'd7, 3'd2);
        #1;
        chk("t1_arready", s_arready, 3'b001);
        cycle();
        chk("t1_arvalid", m_arvalid, 1'b1);
        chk("t1_arid", m_arid, 4'd0);
        chk("t1_arburst", m_arburst, 2'b01);
        chk("t1_araddr", m_araddr, 32'h1FC0_0040);
        drain("t1_drain", 40);
        chk("t1_beats0", delivered[0], 8);
        chk("t1_beats12", delivered[1] + delivered[2], 0);
        chk("t1_last", last_data[0], 32'hA7);

        // Uncache and ICache at once
        clear_logs();
        sl_base = 32'hB0;
        set_req(1, 32'hBFAF_F000, 8'd0, 3'd2);
        set_req(2, 32'h1FC0_0000, 8'd7, 3'd2);
        drain("t2_drain", 60);
        chk("t2_ngrants", grant_idx_q.size(), 2);
        if (grant_idx_q.size() >= 2 && rlast_cyc_q.size() >= 1) begin
            chk("t2_first", grant_idx_q[0], 1);
            chk("t2_second", grant_idx_q[1], 2);
            chk("t2_gap", grant_cyc_q[1], rlast_cyc_q[0] + 1);
        end
        chk("t2_beats", delivered[1] * 16 + delivered[2], 16 + 8);

        // m_arready low for 5 cycles
        clear_logs();
        sl_base = 32'h30;
        ar_ready_en = 1'b0;
        m_arready = 1'b0;
        set_req(0, 32'h1234_5678, 8'd3, 3'd2);
        cycle();
        set_req(2, 32'h0000_0100, 8'd1, 3'd1);
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("t3_arvalid", m_arvalid, 1'b1);
            chk("t3_araddr", m_araddr, 32'h1234_5678);
            chk("t3_arlen", m_arlen, 8'd3);
            chk("t3_arsize", m_arsize, 3'd2);
            chk("t3_arready", s_arready, 3'b000);
        end
        ar_ready_en = 1'b1;
        drain("t3_drain", 60);
        chk("t3_order", grant_idx_q.size() * 10 + (grant_idx_q.size() >= 2 ? grant_idx_q[1] : 9), 22);

        // Owner stalls on beat 3
        clear_logs();
        sl_base = 32'hA0;
        set_req(0, 32'h1FC0_0040, 8'd7, 3'd2);
        for (int n = 0; n < 20; n++) begin
            if (sl_left > 0 && sl_idx == 3) break;
            cycle();
        end
        s_rready[0] = 1'b0;
        #1;
        chk("t4_mrready", m_rready, 1'b0);
        chk("t4_rvalid", s_rvalid, 3'b001);
        chk("t4_rdata", s_rdata, 32'hA3);
        cycle();
        cycle();
        chk("t4_stalled", delivered[0], 3);
        s_rready[0] = 1'b1;
        drain("t4_drain", 40);
        chk("t4_beats", delivered[0], 8);
        chk("t4_last", last_data[0], 32'hA7);

        // Reset in the middle of a burst
        clear_logs();
        sl_base = 32'hC0;
        set_req(0, 32'h1FC0_0000, 8'd7, 3'd2);
        for (int n = 0; n < 30; n++) begin
            if (delivered[0] == 4) break;
            cycle();
        end
        chk("t5_mid", delivered[0], 4);
        rst = 1'b1;
        #1;
        chk("t5_state", o_dbg_state, ARB_IDLE);
        chk("t5_rvalid", s_rvalid, 3'b000);
        chk("t5_rdata", s_rdata, 32'h0);
        chk("t5_mrready", m_rready, 1'b0);
        chk("t5_arvalid", m_arvalid, 1'b0);
        chk("t5_araddr", m_araddr, 32'h0);
        chk("t5_arburst", m_arburst, 2'b00);
        model_reset();
        exp_q.delete();
        sl_left = 0; sl_idx = 0;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        s_arvalid = '0;
        cycle();
        cycle();
        rst = 1'b0;
        clear_logs();
        sl_base = 32'hD0;
        set_req(0, 32'h1FC0_0080, 8'd1, 3'd2);
        drain("t5_drain", 30);
        chk("t5_grant", grant_idx_q.size() * 10 + (grant_idx_q.size() >= 1 ? grant_idx_q[0] : 9), 10);
        chk("t5_beats", delivered[0], 2);
        chk("t5_last", last_data[0], 32'hD1);

        // All three requesting continuously, single beats
        rst = 1'b1;
        model_reset();
        cycle();
        rst = 1'b0;
        clear_logs();
        hold_req = 1'b1;
        sl_base = 32'hE0;
        set_req(0, 32'h0000_0100, 8'd0, 3'd2);
        set_req(1, 32'h0000_0200, 8'd0, 3'd2);
        set_req(2, 32'h0000_0300, 8'd0, 3'd2);
        for (int n = 0; n < 60; n++) begin
            if (grant_idx_q.size() >= 5) break;
            cycle();
        end
        s_arvalid = '0;
        hold_req = 1'b0;
        drain("t6_drain", 20);
        chk("t6_ngrants", grant_idx_q.size() >= 5, 1'b1);
        if (grant_idx_q.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("t6_seq", grant_idx_q[k], exp_seq[k]);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
